wb_search_engine: RTL and testbench

- Wishbone-classic slave inside the user project that holds a small word table plus a key/mask.
- On a start command it scans the table sequentially, one entry per clock, for the first masked match.
- It reports the match index through a readable result register and raises an interrupt line.
- It sits directly downstream of the wrapper's Wishbone and user_irq ports: it consumes wbs_* and drives wbs_dat_o, wbs_ack_o and irq_o (mapped to user_irq[0]).

---
 rtl/search_pkg.sv | 35 +++
 rtl/search_table.sv | 28 ++
 rtl/wb_search_engine.sv | 162 ++++++++++++++++
 tb/tb_wb_search_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/search_pkg.sv
// Shared constants, register map and state type for the Wishbone table search engine.
package search_pkg;

    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_STATUS     = 8'h04;
    localparam logic [7:0] OFF_KEY        = 8'h08;
    localparam logic [7:0] OFF_MASK       = 8'h0C;
    localparam logic [7:0] OFF_RESULT     = 8'h10;
    localparam logic [7:0] OFF_TABLE_BASE = 8'h80;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int STATUS_BUSY_BIT   = 0;
    localparam int STATUS_DONE_BIT   = 1;
    localparam int STATUS_FOUND_BIT  = 2;

    localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/search_table.sv
// DEPTH x 32 word table: byte-enabled bus write, combinational bus read and scan read.
import search_pkg::*;

module search_table #(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [3:0]       i_sel,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata,
    input  logic [IDX_W-1:0] i_scan_idx,
    output logic [31:0]      o_scan_data
);

    // Contents are intentionally left unreset.
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_addr] <= apply_sel(r_mem[i_addr], i_wdata, i_sel);
    end

    assign o_rdata     = r_mem[i_addr];
    assign o_scan_data = r_mem[i_scan_idx];

endmodule

// File: rtl/wb_search_engine.sv
// Wishbone slave holding a word table and key/mask; scans for the first masked match
// one entry per clock and reports the index plus a level interrupt.
//   state | meaning
//   IDLE  | waiting for START; registers freely writable
//   SCAN  | comparing table[idx] each cycle; KEY/MASK/table writes dropped
import search_pkg::*;

module wb_search_engine #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IDX_W     = $clog2(DEPTH)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq_o,
    output logic        busy_o
);

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_done, r_found, r_irq_en;
    logic [31:0]       r_key, r_mask, r_result;
    logic              r_ack;
    logic [31:0]       r_dat;

    logic              w_hit, w_acc, w_wr, w_busy;
    logic [7:0]        w_off;
    logic [4:0]        w_tbl_word;
    logic              w_tbl_hit;
    logic [IDX_W-1:0]  w_tbl_idx;
    logic              w_wr_ctrl, w_start, w_w1c_done, w_wr_key, w_wr_mask, w_tbl_we;
    logic [31:0]       w_tbl_rdata, w_scan_data, w_rdata;
    logic              w_match, w_last, w_scan_end;
    logic              w_unused_adr;

    assign w_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // A strobe held across the ack cycle is only accepted again once ack drops.
    assign w_acc  = w_hit & ~r_ack;
    assign w_wr   = w_acc & wbs_we_i;
    assign w_busy = (r_state == SCAN);

    assign w_off        = {wbs_adr_i[7:2], 2'b00};
    assign w_unused_adr = ^wbs_adr_i[1:0];
    assign w_tbl_word   = wbs_adr_i[6:2];
    assign w_tbl_hit    = wbs_adr_i[7] && (32'(w_tbl_word) < 32'(DEPTH));
    assign w_tbl_idx    = IDX_W'(w_tbl_word);

    assign w_wr_ctrl  = w_wr & (w_off == OFF_CTRL) & wbs_sel_i[0];
    assign w_start    = w_wr_ctrl & wbs_dat_i[CTRL_START_BIT] & ~w_busy;
    assign w_w1c_done = w_wr & (w_off == OFF_STATUS) & wbs_sel_i[0] & wbs_dat_i[STATUS_DONE_BIT];
    assign w_wr_key   = w_wr & (w_off == OFF_KEY) & ~w_busy;
    assign w_wr_mask  = w_wr & (w_off == OFF_MASK) & ~w_busy;
    assign w_tbl_we   = w_wr & w_tbl_hit & ~w_busy;

    search_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .i_clk       (wb_clk_i),
        .i_we        (w_tbl_we),
        .i_sel       (wbs_sel_i),
        .i_addr      (w_tbl_idx),
        .i_wdata     (wbs_dat_i),
        .o_rdata     (w_tbl_rdata),
        .i_scan_idx  (r_idx),
        .o_scan_data (w_scan_data)
    );

    assign w_match = ((w_scan_data ^ r_key) & r_mask) == 32'd0;
    assign w_last  = (r_idx == IDX_W'(DEPTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_scan_end  = 1'b0;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = SCAN;
            SCAN: begin
                if (w_match || w_last) begin
                    w_state_nxt = IDLE;
                    w_scan_end  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_tbl_hit) begin
            w_rdata = w_tbl_rdata;
        end else begin
            case (w_off)
                OFF_CTRL:   w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
                OFF_STATUS: begin
                    w_rdata[STATUS_BUSY_BIT]  = w_busy;
                    w_rdata[STATUS_DONE_BIT]  = r_done;
                    w_rdata[STATUS_FOUND_BIT] = r_found;
                end
                OFF_KEY:    w_rdata = r_key;
                OFF_MASK:   w_rdata = r_mask;
                OFF_RESULT: w_rdata = r_result;
                default:    w_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_found  <= 1'b0;
            r_irq_en <= 1'b0;
            r_key    <= 32'd0;
            r_mask   <= 32'd0;
            r_result <= NOT_FOUND;
            r_ack    <= 1'b0;
            r_dat    <= 32'd0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wbs_we_i) ? w_rdata : 32'd0;

            if (w_wr_ctrl) r_irq_en <= wbs_dat_i[CTRL_IRQ_EN_BIT];
            if (w_wr_key)  r_key    <= apply_sel(r_key, wbs_dat_i, wbs_sel_i);
            if (w_wr_mask) r_mask   <= apply_sel(r_mask, wbs_dat_i, wbs_sel_i);

            if (w_start) begin
                r_idx   <= '0;
                r_found <= 1'b0;
            end else if (w_busy) begin
                r_idx <= r_idx + IDX_W'(1);
            end

            // FSM completion beats a same-edge write-1-to-clear.
            if (w_scan_end)                r_done <= 1'b1;
            else if (w_start || w_w1c_done) r_done <= 1'b0;

            if (w_scan_end) begin
                r_found  <= w_match;
                r_result <= w_match ? 32'(r_idx) : NOT_FOUND;
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq_o     = r_done & r_irq_en;
    assign busy_o    = w_busy;

endmodule

// File: tb/tb_wb_search_engine.sv
// Scoreboard bench for wb_search_engine: bus tasks queue expected read data, a negedge
// monitor pops and compares on every ack.
module tb_wb_search_engine;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'd0, dat_w = 32'd0;
    logic [31:0] dat_r;
    logic        ack, irq, busy;

    always #5 clk = ~clk;

    wb_search_engine #(
        .DEPTH     (16),
        .BASE_ADDR (BASE)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_dat_o  (dat_r),
        .wbs_ack_o  (ack),
        .irq_o      (irq),
        .busy_o     (busy)
    );

    typedef struct {
        logic        is_rd;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_ack = 1'b0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (ack) begin
                checks++;
                if (prev_ack) begin
                    errors++;
                    $display("FAIL ack_width: ack high on two consecutive cycles, required one");
                end
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: ack with no pending access, adr=%h", adr);
                end else begin
                    mon_e = sbq.pop_front();
                    if (mon_e.is_rd) begin
                        checks++;
                        if (dat_r !== mon_e.exp) begin
                            errors++;
                            $display("FAIL %s: got %h required %h", mon_e.name, dat_r, mon_e.exp);
                        end
                    end
                end
            end
            prev_ack = ack;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp, input string name);
        exp_t e;
        logic got;
        e.is_rd = !w;
        e.exp   = exp;
        e.name  = name;
        sbq.push_back(e);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 8 cycles, required ack", name);
            void'(sbq.pop_back());
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input string name);
        bus(1'b1, BASE + 32'(off), d, 4'hF, 32'd0, name);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        bus(1'b0, BASE + 32'(off), 32'd0, 4'hF, exp, name);
    endtask

    task automatic wait_done(input int exp_edges, input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n), 32'(exp_edges));
    endtask

    task automatic no_ack(input logic w, input logic [31:0] a, input logic [31:0] d, input string name);
        int acks;
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk(name, 32'(acks), 32'd0);
    endtask

    task automatic b2b_read(input logic [7:0] off, input logic [31:0] exp, input string name);
        exp_t e;
        int acks;
        e.is_rd = 1'b1;
        e.exp   = exp;
        e.name  = name;
        sbq.push_back(e);
        sbq.push_back(e);
        acks = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'(off); sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        chk({name, "_ack_count"}, 32'(acks), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rd(8'h00, 32'd0, "reset_ctrl");
        rd(8'h04, 32'd0, "reset_status");
        rd(8'h10, 32'hFFFF_FFFF, "reset_result");
        rd(8'h08, 32'd0, "reset_key");
        rd(8'h0C, 32'd0, "reset_mask");

        // basic match at index 5
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(4 * i), 32'(i) * 32'h11, "fill");
        wr(8'h08, 32'h55, "key");
        wr(8'h0C, 32'hFFFF_FFFF, "mask");
        rd(8'h94, 32'h55, "table5_rb");
        wr(8'h00, 32'd3, "start");
        wait_done(6, "match_latency");
        chk("match_irq", 32'(irq), 32'd1);
        rd(8'h04, 32'd6, "match_status");
        rd(8'h10, 32'd5, "match_result");
        rd(8'h00, 32'd2, "ctrl_start_reads0");
        wr(8'h04, 32'd2, "w1c");
        chk("w1c_irq", 32'(irq), 32'd0);
        rd(8'h04, 32'd4, "w1c_status");

        // no match
        wr(8'h08, 32'hDEAD_BEEF, "key_nm");
        wr(8'h00, 32'd3, "start_nm");
        wait_done(16, "nomatch_latency");
        rd(8'h04, 32'd2, "nomatch_status");
        rd(8'h10, 32'hFFFF_FFFF, "nomatch_result");
        chk("nomatch_irq", 32'(irq), 32'd1);

        // masked match, byte selects
        for (int i = 0; i < 16; i++) wr(8'h80 + 8'(4 * i), (i == 9) ? 32'h12AB_3456 : 32'd0, "fill2");
        bus(1'b1, BASE + 32'h08, 32'h00AB_0000, 4'b0100, 32'd0, "key_sel");
        rd(8'h08, 32'hDEAB_BEEF, "key_sel_rb");
        wr(8'h0C, 32'h00FF_0000, "mask_b2");
        wr(8'h00, 32'd3, "start_mask");
        wait_done(10, "masked_latency");
        rd(8'h10, 32'd9, "masked_result");
        rd(8'h04, 32'd6, "masked_status");

        // MASK=0 matches entry 0
        wr(8'h0C, 32'd0, "mask0");
        wr(8'h00, 32'd3, "start_mask0");
        wait_done(1, "mask0_latency");
        rd(8'h10, 32'd0, "mask0_result");

        // writes during busy are acked and dropped
        wr(8'h0C, 32'h00FF_0000, "mask_b2_again");
        wr(8'h00, 32'd3, "start_busy");
        wr(8'h00, 32'd3, "start_in_scan");
        wr(8'h08, 32'h1111_1111, "key_in_scan");
        wr(8'h8C, 32'hFFFF_FFFF, "table3_in_scan");
        rd(8'h8C, 32'd0, "table3_read_busy");
        wait_done(2, "busy_scan_latency");
        rd(8'h08, 32'hDEAB_BEEF, "key_unchanged");
        rd(8'h8C, 32'd0, "table3_unchanged");
        rd(8'h10, 32'd9, "busy_result");
        rd(8'h04, 32'd6, "busy_status");
        repeat (3) @(posedge clk);
        #1 chk("no_restart", 32'(busy), 32'd0);

        // unmapped offsets, back-to-back strobes, out-of-window
        rd(8'h20, 32'd0, "unmapped_rd");
        wr(8'hC0, 32'hCAFE_F00D, "beyond_table_wr");
        rd(8'hC0, 32'd0, "beyond_table_rd");
        b2b_read(8'h10, 32'd9, "b2b_result");
        no_ack(1'b0, BASE + 32'h100, 32'd0, "oow_read");
        no_ack(1'b1, BASE + 32'h108, 32'h1234_5678, "oow_write");
        rd(8'h08, 32'hDEAB_BEEF, "oow_key_unchanged");

        // reset during scan cycle 4
        wr(8'h08, 32'hDEAD_BEEF, "key_rst");
        wr(8'h0C, 32'hFFFF_FFFF, "mask_rst");
        wr(8'h00, 32'd3, "start_rst");
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        rd(8'h04, 32'd0, "midreset_status");
        rd(8'h00, 32'd0, "midreset_ctrl");
        rd(8'h10, 32'hFFFF_FFFF, "midreset_result");
        rd(8'h08, 32'd0, "midreset_key");
        rd(8'hA4, 32'h12AB_3456, "table_survives_reset");

        repeat (4) @(posedge clk);
        #1 chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
